vc_demux: RTL

Parametrised virtual-channel demultiplexer between the main FIFO pop side and the per-VC FIFOs. Each accepted word is steered to one of NUM_VC output slots by a VC-id field inside the word, one cycle after acceptance. Each output slot is a registered holding stage: it stalls on per-channel downstream pause and back-pressures the main FIFO through `ready_in`. Words with an out-of-range VC id are dropped and flagged.

---
 rtl/vc_demux_pkg.sv | 26 ++
 rtl/vc_demux_if.sv | 31 +++
 rtl/vc_demux_slot.sv | 77 +++++++
 rtl/vc_demux.sv | 89 ++++++++
 4 files changed

// File: rtl/vc_demux_pkg.sv
// Shared definitions for the virtual-channel demultiplexer.
//   DATA_W_DEF / NUM_VC_DEF : default word width and channel count
//   slot_state_e            : per-slot holding-stage state (EMPTY / FULL)
//   vc_id()                 : extracts the VC-id field from a word
package vc_pkg;

  localparam int DATA_W_DEF  = 6;
  localparam int NUM_VC_DEF  = 2;
  localparam int VC_ID_MAX_W = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // The word is zero-extended to 64 bits by the caller so one function
  // serves every DATA_W; the result is truncated to the field width there.
  function automatic logic [VC_ID_MAX_W-1:0] vc_id(input logic [63:0] word,
                                                   input int lsb,
                                                   input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return VC_ID_MAX_W'((word >> lsb) & mask);
  endfunction

endpackage

// File: rtl/vc_demux_if.sv
// Bus between the main FIFO pop side, the demux and the per-VC FIFOs.
//   valid_in/data_in/ready_in : input handshake from the main FIFO
//   pause                     : per-channel downstream stall
//   valid_out/data_out        : per-channel holding-stage outputs (flat bus)
//   err_vc                    : pulse when an out-of-range VC id is dropped
// Handshake: a word transfers in a cycle where valid_in && ready_in.
// ready_in never depends on valid_in; once valid_in is raised the source
// holds data_in stable until the transfer. Output slot i is consumed by
// downstream in any cycle where valid_out[i] && !pause[i].
interface vc_demux_if #(
  parameter int DATA_W = vc_pkg::DATA_W_DEF,
  parameter int NUM_VC = vc_pkg::NUM_VC_DEF
);
  logic                     valid_in;
  logic [DATA_W-1:0]        data_in;
  logic                     ready_in;
  logic [NUM_VC-1:0]        pause;
  logic [NUM_VC-1:0]        valid_out;
  logic [NUM_VC*DATA_W-1:0] data_out;
  logic                     err_vc;

  modport master (
    output valid_in, data_in, pause,
    input  ready_in, valid_out, data_out, err_vc
  );

  modport slave (
    input  valid_in, data_in, pause,
    output ready_in, valid_out, data_out, err_vc
  );
endinterface

// File: rtl/vc_demux_slot.sv
// Single-channel registered holding stage.
//   clk, reset : clock, asynchronous active-high reset
//   load       : write din into the slot this cycle
//   din        : word to load
//   pause      : downstream stall for this channel
//   can_load   : slot is empty or drains this cycle
//   valid/dout : held word (dout is zero when empty)
//   state      : current EMPTY/FULL state
//   count      : drain counter, present with VC_DEMUX_STATS_EN
module vc_demux_slot
  import vc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              pause,
  output logic              can_load,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output slot_state_e       state
`ifdef VC_DEMUX_STATS_EN
  ,
  output logic [STAT_W-1:0] count
`endif
);

  logic drain;

  assign drain    = (state == SLOT_FULL) && !pause;
  assign can_load = (state == SLOT_EMPTY) || drain;
  assign valid    = (state == SLOT_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SLOT_EMPTY;
      dout  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state <= SLOT_FULL;
            dout  <= din;
          end
        end
        SLOT_FULL: begin
          // Load only arrives when can_load, so a load here means either
          // the slot drains this cycle (replace) or it was never paused.
          if (load) begin
            dout <= din;
          end else if (drain) begin
            state <= SLOT_EMPTY;
            dout  <= '0;
          end
        end
        default: begin
          state <= SLOT_EMPTY;
          dout  <= '0;
        end
      endcase
    end
  end

`ifdef VC_DEMUX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (drain) begin
      count <= count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/vc_demux.sv
// Virtual-channel demultiplexer: steers each accepted word to one of
// NUM_VC registered output slots by the VC-id field data_in[VC_LSB +: VC_W].
// Words whose id is >= NUM_VC are dropped and flagged on err_vc.
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : vc_demux_if slave (input handshake, pause, slot outputs)
//   slot_state  : per-slot EMPTY/FULL state for observation
//   pkt_count   : per-slot drain counters (only with VC_DEMUX_STATS_EN)
// Optional feature macro: VC_DEMUX_STATS_EN
module vc_demux
  import vc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int VC_LSB = DATA_W - 1,
  parameter int VC_W   = $clog2(NUM_VC),
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  vc_demux_if.slave                bus,
  output slot_state_e [NUM_VC-1:0] slot_state
`ifdef VC_DEMUX_STATS_EN
  ,
  output logic [NUM_VC*STAT_W-1:0] pkt_count
`endif
);

  logic [VC_W-1:0]          sel;
  logic                     bad;
  logic                     can_sel;
  logic                     ready;
  logic                     accept;
  logic [NUM_VC-1:0]        can_load;
  logic [NUM_VC-1:0]        load;
  logic [NUM_VC-1:0]        valid_vec;
  logic [NUM_VC*DATA_W-1:0] data_vec;
  logic                     err_q;

  always_comb begin
    sel     = VC_W'(vc_id(64'(bus.data_in), VC_LSB, VC_W));
    bad     = (32'(sel) >= NUM_VC);
    // Only the targeted slot gates the input: no bypass around a paused one.
    can_sel = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (32'(sel) == i) can_sel = can_load[i];
    end
    ready  = !reset && (bad || can_sel);
    accept = bus.valid_in && ready;
    load   = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      load[i] = accept && !bad && (32'(sel) == i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && bad;
    end
  end

  for (genvar i = 0; i < NUM_VC; i++) begin : g_slot
    vc_demux_slot #(
      .DATA_W(DATA_W),
      .STAT_W(STAT_W)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (load[i]),
      .din      (bus.data_in),
      .pause    (bus.pause[i]),
      .can_load (can_load[i]),
      .valid    (valid_vec[i]),
      .dout     (data_vec[i*DATA_W +: DATA_W]),
      .state    (slot_state[i])
`ifdef VC_DEMUX_STATS_EN
      ,
      .count    (pkt_count[i*STAT_W +: STAT_W])
`endif
    );
  end

  assign bus.ready_in  = ready;
  assign bus.valid_out = valid_vec;
  assign bus.data_out  = data_vec;
  assign bus.err_vc    = err_q;

endmodule
